z3_dma_master: RTL and testbench

- Zorro III bus-master sequencer for the NCR 53C710 DMA path, upstream of the slave decode/buffer logic.
- Arbitrates for the Zorro III bus on behalf of the 710 (SBR/SBG) and drives BMASTER.
- Converts each 710 master access into a Zorro III master cycle: FCS_n, DS_n lanes, DOE, MTCR_n.
- Returns STERM_n or BERR_n to the 710.

---
 rtl/z3_dma_master.sv | 250 +++++++++++++++++++++++++
 tb/tb_z3_dma_master.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/z3_dma_master.sv
// Zorro III bus-master sequencer for the NCR 53C710 DMA path: bus arbitration plus
// translation of each 710 access into a single Zorro III full cycle.
module z3_dma_master #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int ADDR_SETUP     = 1
) (
  input  logic       CLK,
  input  logic       IORST_n,
  input  logic       SBR,
  output logic       SBG,
  output logic       BR_n,
  input  logic       BG_n,
  input  logic       Z_FCS_n,
  input  logic       NCR_AS_n,
  input  logic       NCR_READ,
  input  logic [1:0] NCR_SIZ,
  input  logic [1:0] NCR_A,
  input  logic       DTACK_n,
  input  logic       BERR_n,
  output logic       BMASTER,
  output logic       ABOE_n,
  output logic       FCS_n,
  output logic [3:0] DS_n,
  output logic       READ_OUT,
  output logic       DOE,
  output logic       MTCR_n,
  output logic       NCR_STERM_n,
  output logic       NCR_BERR_n
);

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_REQ  = 2'd1,
    ARB_OWN  = 2'd2
  } arb_t;

  typedef enum logic [2:0] {
    C_IDLE = 3'd0,
    C_ADDR = 3'd1,
    C_FCS  = 3'd2,
    C_WAIT = 3'd3,
    C_TERM = 3'd4
  } cyc_t;

  localparam logic [1:0] SETUP_LAST = 2'(ADDR_SETUP - 1);
  localparam logic [7:0] TMO_LAST   = 8'(TIMEOUT_CYCLES - 1);

  // Active-low data strobes for a 710 transfer; [3] carries D31:24.
  function automatic logic [3:0] lane_ds_n(input logic [1:0] siz, input logic [1:0] a);
    logic [3:0] ds;
    case (siz)
      2'b01: begin
        ds = 4'hF;
        ds[2'd3 - a] = 1'b0;
      end
      2'b10:   ds = a[1] ? 4'b1100 : 4'b0011;
      2'b11:   ds = (a == 2'b00) ? 4'b0001 : 4'b1000;
      2'b00:   ds = 4'b0000;
      default: ds = 4'hF;
    endcase
    return ds;
  endfunction

  logic [4:0] r_sync_a, r_sync_b;
  logic       w_bg_n, w_zfcs_n, w_as_n, w_dtack_n, w_berr_n;

  arb_t       r_arb, w_arb_nx;
  cyc_t       r_cyc, w_cyc_nx;
  logic       w_release, w_start, w_lat_en;

  logic       r_read;
  logic [1:0] r_siz, r_a;
  logic [1:0] r_setup, w_setup_nx;
  logic [7:0] r_tmo, w_tmo_nx;

  logic       r_br_n, r_sbg, r_bmaster;
  logic       r_aboe_n, r_fcs_n, r_read_out, r_doe, r_sterm_n, r_berr_n;
  logic [3:0] r_ds_n;
  logic       w_aboe_n_nx, w_fcs_n_nx, w_read_out_nx, w_doe_nx, w_sterm_n_nx, w_berr_n_nx;
  logic [3:0] w_ds_n_nx;

  assign w_bg_n    = r_sync_b[4];
  assign w_zfcs_n  = r_sync_b[3];
  assign w_as_n    = r_sync_b[2];
  assign w_dtack_n = r_sync_b[1];
  assign w_berr_n  = r_sync_b[0];

  // Two-flop synchronisers for the asynchronous bus and 710 strobes.
  always_ff @(posedge CLK or negedge IORST_n) begin
    if (!IORST_n) begin
      r_sync_a <= 5'h1F;
      r_sync_b <= 5'h1F;
    end else begin
      r_sync_a <= {BG_n, Z_FCS_n, NCR_AS_n, DTACK_n, BERR_n};
      r_sync_b <= r_sync_a;
    end
  end

  // Ownership is only released once no Zorro cycle is in flight.
  assign w_release = (r_arb == ARB_OWN) && !SBR && (r_cyc == C_IDLE);
  assign w_start   = (r_arb == ARB_OWN) && !w_release && !w_as_n;

  // Arbiter next-state.
  always_comb begin
    w_arb_nx = r_arb;
    case (r_arb)
      ARB_IDLE: begin
        if (SBR) w_arb_nx = ARB_REQ;
        else     w_arb_nx = ARB_IDLE;
      end
      ARB_REQ: begin
        if (!SBR)                                   w_arb_nx = ARB_IDLE;
        else if (!w_bg_n && w_zfcs_n && w_dtack_n)  w_arb_nx = ARB_OWN;
        else                                        w_arb_nx = ARB_REQ;
      end
      ARB_OWN: begin
        if (w_release) w_arb_nx = ARB_IDLE;
        else           w_arb_nx = ARB_OWN;
      end
      default: w_arb_nx = ARB_IDLE;
    endcase
  end

  // Cycle next-state; strobe outputs change on the edge that leaves each state.
  always_comb begin
    w_cyc_nx      = r_cyc;
    w_lat_en      = 1'b0;
    w_setup_nx    = r_setup;
    w_tmo_nx      = r_tmo;
    w_aboe_n_nx   = r_aboe_n;
    w_fcs_n_nx    = r_fcs_n;
    w_ds_n_nx     = r_ds_n;
    w_read_out_nx = r_read_out;
    w_doe_nx      = r_doe;
    w_sterm_n_nx  = 1'b1;
    w_berr_n_nx   = 1'b1;
    case (r_cyc)
      C_IDLE: begin
        if (w_start) begin
          w_cyc_nx    = C_ADDR;
          w_lat_en    = 1'b1;
          w_aboe_n_nx = 1'b0;
          w_setup_nx  = 2'd0;
        end else begin
          w_cyc_nx = C_IDLE;
        end
      end
      C_ADDR: begin
        if (r_setup >= SETUP_LAST) begin
          w_cyc_nx      = C_FCS;
          w_fcs_n_nx    = 1'b0;
          w_read_out_nx = r_read;
        end else begin
          w_setup_nx = r_setup + 2'd1;
        end
      end
      C_FCS: begin
        w_cyc_nx  = C_WAIT;
        w_ds_n_nx = lane_ds_n(r_siz, r_a);
        w_doe_nx  = !r_read;
        w_tmo_nx  = 8'd0;
      end
      C_WAIT: begin
        w_tmo_nx = (r_tmo == 8'hFF) ? r_tmo : r_tmo + 8'd1;
        if (!w_berr_n || (r_tmo >= TMO_LAST)) begin
          w_cyc_nx    = C_TERM;
          w_berr_n_nx = 1'b0;
        end else if (!w_dtack_n) begin
          w_cyc_nx     = C_TERM;
          w_sterm_n_nx = 1'b0;
        end else begin
          w_cyc_nx = C_WAIT;
        end
      end
      C_TERM: begin
        w_aboe_n_nx   = 1'b1;
        w_fcs_n_nx    = 1'b1;
        w_ds_n_nx     = 4'hF;
        w_read_out_nx = 1'b1;
        w_doe_nx      = 1'b0;
        if (w_dtack_n && w_as_n) w_cyc_nx = C_IDLE;
        else                     w_cyc_nx = C_TERM;
      end
      default: begin
        w_cyc_nx      = C_IDLE;
        w_aboe_n_nx   = 1'b1;
        w_fcs_n_nx    = 1'b1;
        w_ds_n_nx     = 4'hF;
        w_read_out_nx = 1'b1;
        w_doe_nx      = 1'b0;
      end
    endcase
  end

  // State, access latch, counters and registered outputs.
  always_ff @(posedge CLK or negedge IORST_n) begin
    if (!IORST_n) begin
      r_arb      <= ARB_IDLE;
      r_cyc      <= C_IDLE;
      r_read     <= 1'b1;
      r_siz      <= 2'b00;
      r_a        <= 2'b00;
      r_setup    <= 2'd0;
      r_tmo      <= 8'd0;
      r_br_n     <= 1'b1;
      r_sbg      <= 1'b0;
      r_bmaster  <= 1'b0;
      r_aboe_n   <= 1'b1;
      r_fcs_n    <= 1'b1;
      r_ds_n     <= 4'hF;
      r_read_out <= 1'b1;
      r_doe      <= 1'b0;
      r_sterm_n  <= 1'b1;
      r_berr_n   <= 1'b1;
    end else begin
      r_arb      <= w_arb_nx;
      r_cyc      <= w_cyc_nx;
      if (w_lat_en) begin
        r_read <= NCR_READ;
        r_siz  <= NCR_SIZ;
        r_a    <= NCR_A;
      end
      r_setup    <= w_setup_nx;
      r_tmo      <= w_tmo_nx;
      r_br_n     <= (w_arb_nx == ARB_IDLE);
      r_sbg      <= (w_arb_nx == ARB_OWN);
      r_bmaster  <= (w_arb_nx == ARB_OWN);
      r_aboe_n   <= w_aboe_n_nx;
      r_fcs_n    <= w_fcs_n_nx;
      r_ds_n     <= w_ds_n_nx;
      r_read_out <= w_read_out_nx;
      r_doe      <= w_doe_nx;
      r_sterm_n  <= w_sterm_n_nx;
      r_berr_n   <= w_berr_n_nx;
    end
  end

  assign BR_n        = r_br_n;
  assign SBG         = r_sbg;
  assign BMASTER     = r_bmaster;
  assign ABOE_n      = r_aboe_n;
  assign FCS_n       = r_fcs_n;
  assign DS_n        = r_ds_n;
  assign READ_OUT    = r_read_out;
  assign DOE         = r_doe;
  assign MTCR_n      = 1'b1;
  assign NCR_STERM_n = r_sterm_n;
  assign NCR_BERR_n  = r_berr_n;

endmodule

// File: tb/tb_z3_dma_master.sv
// Directed bench for z3_dma_master: arbitration, lane decode, termination,
// timeout, BERR priority and asynchronous reset mid-cycle.
module tb_z3_dma_master;

  logic       CLK = 1'b0;
  logic       IORST_n, SBR, BG_n, Z_FCS_n, NCR_AS_n, NCR_READ, DTACK_n, BERR_n;
  logic [1:0] NCR_SIZ, NCR_A;
  logic       SBG, BR_n, BMASTER, ABOE_n, FCS_n, READ_OUT, DOE, MTCR_n, NCR_STERM_n, NCR_BERR_n;
  logic [3:0] DS_n;

  int n_total = 0;
  int n_bad   = 0;

  z3_dma_master #(.TIMEOUT_CYCLES(255), .ADDR_SETUP(1)) dut (
    .CLK(CLK), .IORST_n(IORST_n), .SBR(SBR), .SBG(SBG), .BR_n(BR_n), .BG_n(BG_n),
    .Z_FCS_n(Z_FCS_n), .NCR_AS_n(NCR_AS_n), .NCR_READ(NCR_READ), .NCR_SIZ(NCR_SIZ),
    .NCR_A(NCR_A), .DTACK_n(DTACK_n), .BERR_n(BERR_n), .BMASTER(BMASTER),
    .ABOE_n(ABOE_n), .FCS_n(FCS_n), .DS_n(DS_n), .READ_OUT(READ_OUT), .DOE(DOE),
    .MTCR_n(MTCR_n), .NCR_STERM_n(NCR_STERM_n), .NCR_BERR_n(NCR_BERR_n)
  );

  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge CLK);
  endtask

  task automatic start_access(input logic rd, input logic [1:0] siz, input logic [1:0] a);
    NCR_READ = rd;
    NCR_SIZ  = siz;
    NCR_A    = a;
    NCR_AS_n = 1'b0;
    for (int i = 0; i < 20 && FCS_n !== 1'b0; i++) tick();
    check_val("fcs_assert", {31'd0, FCS_n}, 32'd0);
    tick();
  endtask

  // Full access terminated by DTACK_n; DS_n/DOE/READ_OUT checked while in C_WAIT.
  task automatic do_xfer(input string tag, input logic rd, input logic [1:0] siz,
                         input logic [1:0] a, input logic [3:0] exp_ds);
    start_access(rd, siz, a);
    check_val({tag, "_ds"}, {28'd0, DS_n}, {28'd0, exp_ds});
    check_val({tag, "_doe"}, {31'd0, DOE}, {31'd0, ~rd});
    check_val({tag, "_rdout"}, {31'd0, READ_OUT}, {31'd0, rd});
    repeat (3) tick();
    DTACK_n = 1'b0;
    for (int i = 0; i < 10 && NCR_STERM_n !== 1'b0; i++) tick();
    check_val({tag, "_sterm"}, {31'd0, NCR_STERM_n}, 32'd0);
    check_val({tag, "_noberr"}, {31'd0, NCR_BERR_n}, 32'd1);
    tick();
    check_val({tag, "_sterm1"}, {31'd0, NCR_STERM_n}, 32'd1);
    check_val({tag, "_fcs_rise"}, {31'd0, FCS_n}, 32'd1);
    NCR_AS_n = 1'b1;
    DTACK_n  = 1'b1;
    repeat (4) tick();
  endtask

  int  cnt;
  logic sterm_seen;

  initial begin
    IORST_n = 1'b0; SBR = 1'b0; BG_n = 1'b1; Z_FCS_n = 1'b1; NCR_AS_n = 1'b1;
    NCR_READ = 1'b1; NCR_SIZ = 2'b00; NCR_A = 2'b00; DTACK_n = 1'b1; BERR_n = 1'b1;
    repeat (3) tick();
    check_val("rst_br", {31'd0, BR_n}, 32'd1);
    check_val("rst_sbg", {31'd0, SBG}, 32'd0);
    check_val("rst_bm", {31'd0, BMASTER}, 32'd0);
    check_val("rst_aboe", {31'd0, ABOE_n}, 32'd1);
    check_val("rst_fcs", {31'd0, FCS_n}, 32'd1);
    check_val("rst_ds", {28'd0, DS_n}, 32'hF);
    check_val("rst_rdout", {31'd0, READ_OUT}, 32'd1);
    check_val("rst_doe", {31'd0, DOE}, 32'd0);
    check_val("rst_mtcr", {31'd0, MTCR_n}, 32'd1);
    check_val("rst_sterm", {31'd0, NCR_STERM_n}, 32'd1);
    check_val("rst_berr", {31'd0, NCR_BERR_n}, 32'd1);
    IORST_n = 1'b1;
    tick();

    // Arbitration: request, grant after two sync flops, release on one edge
    SBR = 1'b1;
    tick();
    check_val("arb_br", {31'd0, BR_n}, 32'd0);
    check_val("arb_bm_pre", {31'd0, BMASTER}, 32'd0);
    repeat (2) tick();
    BG_n = 1'b0;
    repeat (2) tick();
    check_val("arb_bm_sync", {31'd0, BMASTER}, 32'd0);
    tick();
    check_val("arb_bm", {31'd0, BMASTER}, 32'd1);
    check_val("arb_sbg", {31'd0, SBG}, 32'd1);
    check_val("arb_br_own", {31'd0, BR_n}, 32'd0);
    SBR = 1'b0;
    tick();
    check_val("rel_br", {31'd0, BR_n}, 32'd1);
    check_val("rel_bm", {31'd0, BMASTER}, 32'd0);
    check_val("rel_sbg", {31'd0, SBG}, 32'd0);

    SBR = 1'b1;
    for (int i = 0; i < 10 && BMASTER !== 1'b1; i++) tick();
    check_val("reown", {31'd0, BMASTER}, 32'd1);

    // Lane decode across sizes and alignments
    do_xfer("long_wr", 1'b0, 2'b00, 2'b00, 4'h0);
    do_xfer("byte_rd", 1'b1, 2'b01, 2'b10, 4'hD);
    do_xfer("byte0_wr", 1'b0, 2'b01, 2'b00, 4'h7);
    do_xfer("word_rd", 1'b1, 2'b10, 2'b10, 4'hC);
    do_xfer("tri0_wr", 1'b0, 2'b11, 2'b00, 4'h1);
    do_xfer("tri1_rd", 1'b1, 2'b11, 2'b01, 4'h8);

    // Timeout: no DTACK_n, BERR after 255 cycles in C_WAIT
    start_access(1'b1, 2'b00, 2'b00);
    check_val("tmo_ds", {28'd0, DS_n}, 32'h0);
    cnt = 0;
    sterm_seen = 1'b0;
    while (NCR_BERR_n !== 1'b0 && cnt < 400) begin
      tick();
      cnt++;
      if (NCR_STERM_n === 1'b0) sterm_seen = 1'b1;
    end
    check_val("tmo_cycles", cnt, 32'd255);
    check_val("tmo_no_sterm", {31'd0, sterm_seen}, 32'd0);
    tick();
    check_val("tmo_fcs_rise", {31'd0, FCS_n}, 32'd1);
    check_val("tmo_berr1", {31'd0, NCR_BERR_n}, 32'd1);
    NCR_AS_n = 1'b1;
    repeat (4) tick();

    // BERR beats DTACK in the same cycle; SBR drop mid-cycle keeps ownership
    start_access(1'b0, 2'b00, 2'b00);
    repeat (2) tick();
    SBR = 1'b0;
    tick();
    check_val("hold_bm", {31'd0, BMASTER}, 32'd1);
    DTACK_n = 1'b0;
    BERR_n  = 1'b0;
    for (int i = 0; i < 10 && NCR_BERR_n !== 1'b0 && NCR_STERM_n !== 1'b0; i++) tick();
    check_val("prio_berr", {31'd0, NCR_BERR_n}, 32'd0);
    check_val("prio_sterm", {31'd0, NCR_STERM_n}, 32'd1);
    check_val("prio_bm", {31'd0, BMASTER}, 32'd1);
    tick();
    check_val("prio_sterm_late", {31'd0, NCR_STERM_n}, 32'd1);
    NCR_AS_n = 1'b1;
    DTACK_n  = 1'b1;
    BERR_n   = 1'b1;
    repeat (5) tick();
    check_val("late_rel_bm", {31'd0, BMASTER}, 32'd0);
    check_val("late_rel_br", {31'd0, BR_n}, 32'd1);

    // Asynchronous reset during C_WAIT
    SBR = 1'b1;
    for (int i = 0; i < 10 && BMASTER !== 1'b1; i++) tick();
    check_val("reown2", {31'd0, BMASTER}, 32'd1);
    start_access(1'b0, 2'b10, 2'b00);
    check_val("word_wr_ds", {28'd0, DS_n}, 32'h3);
    repeat (3) tick();
    IORST_n = 1'b0;
    #1;
    check_val("arst_fcs", {31'd0, FCS_n}, 32'd1);
    check_val("arst_ds", {28'd0, DS_n}, 32'hF);
    check_val("arst_br", {31'd0, BR_n}, 32'd1);
    check_val("arst_bm", {31'd0, BMASTER}, 32'd0);
    check_val("arst_doe", {31'd0, DOE}, 32'd0);
    SBR = 1'b0;
    NCR_AS_n = 1'b1;
    repeat (2) tick();
    IORST_n = 1'b1;
    repeat (5) tick();
    check_val("post_br", {31'd0, BR_n}, 32'd1);
    check_val("post_bm", {31'd0, BMASTER}, 32'd0);
    check_val("post_sterm", {31'd0, NCR_STERM_n}, 32'd1);
    check_val("post_berr", {31'd0, NCR_BERR_n}, 32'd1);
    SBR = 1'b1;
    tick();
    check_val("post_req", {31'd0, BR_n}, 32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
